mxu_conv_seq: RTL and testbench
===============================

# mxu_conv_seq

Convolution sequencer between the load/store unit and the 16x16 matrix unit. It accepts one decoded conv command at a time and reads the operand rows from IRAM and WRAM. It streams those rows into the MXU, waits for the array result, then issues the optional activation and pooling steps and reports completion. It owns the `lsu_mxu_*` control and payload lanes for conv, so the LSU only forwards commands and RAM read ports.

## Interface
Parameters:
- `ADDR_W`, 12, IRAM/WRAM row address width
- `LANES`, 16, MXU lanes per operand
- `DATA_W`, 128, row payload width (LANES x int8)
- `TIMEOUT`, 255, drain watchdog limit in cycles (used only with watchdog compiled in)

Ports:
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_vld`  in  1  conv command valid
- `cmd_rdy`  out  1  sequencer idle, command accepted on `cmd_vld & cmd_rdy`
- `cmd_iram_addr`  in  ADDR_W  first IRAM row
- `cmd_iram_dir`  in  1  0: address +1 per beat, 1: address -1
- `cmd_wram_addr`  in  ADDR_W  first WRAM row
- `cmd_wram_dir`  in  1  as `cmd_iram_dir` for WRAM
- `cmd_len`  in  4  beats minus one (K = cmd_len+1, 1..16)
- `cmd_col_len`  in  4  active lanes minus one
- `cmd_acc`  in  1  1: accumulate, suppress clear
- `cmd_act` / `cmd_act_type`  in  1 / 2  activation request / type
- `cmd_pool` / `cmd_pool_size`  in  1 / 2  pooling request / size
- `iram_rd_en`, `iram_rd_addr`  out  1, ADDR_W  IRAM read; data returns next cycle
- `iram_rd_data`  in  DATA_W  IRAM read data
- `wram_rd_en`, `wram_rd_addr`, `wram_rd_data`  same for WRAM
- `mxu_vld`  out  1  operand beat valid
- `mxu_clr`  out  1  clear accumulators
- `mxu_iram_vld` / `mxu_wram_vld`  out  LANES  lane masks
- `mxu_iram_pld` / `mxu_wram_pld`  out  DATA_W  operand rows
- `mxu_act_vld`, `mxu_act_type`  out  1, 2  activation strobe/type
- `mxu_pool_vld`, `mxu_pool_size`  out  1, 2  pooling strobe/size
- `mxu_rdy`  in  1  MXU ready for a new command phase
- `mxu_data_rdy`  in  1  array result settled
- `busy`  out  1  command in flight
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  sticky drain timeout (watchdog build only, else 0)

## Operation
- FSM states: IDLE, CLR, FEED, DRAIN, ACT, POOL, DONE.
- IDLE: `cmd_rdy`=1. On handshake, register every `cmd_*` field, set the beat counter k=0 and go to CLR.
- CLR: wait for `mxu_rdy`=1. In that cycle pulse `mxu_clr`=!acc, then go to FEED.
- FEED: K cycles. Each cycle asserts both `rd_en`.
  - Addresses are start ± k, modulo 2^ADDR_W. Wrap is allowed: 0x000 with dir=1 goes to 0xFFF.
  - After k=K-1, go to DRAIN.
- Beats: `mxu_vld` is `iram_rd_en` delayed one cycle.
  - Payloads pass `*_rd_data` through combinationally.
  - Lane masks are `(2^(col_len+1))-1` while `mxu_vld`, else 0. col_len=15 gives 0xFFFF.
  - FEED never stalls; the MXU accepts every beat.
- DRAIN: wait for `mxu_data_rdy`=1, sampled only after the last beat has been driven. Then go to ACT if act, else POOL if pool, else DONE.
- ACT: wait for `mxu_rdy`. Pulse `mxu_act_vld` for one cycle with the type, then go to POOL/DONE.
- POOL: same as ACT using `mxu_pool_vld`/size, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in all states except IDLE.
- Type/size outputs hold their registered values and matter only with their strobes.
- Reset mid-command abandons it immediately: no `done`, no further RAM reads.

## Timing
- Reset value of every output is 0, except `cmd_rdy`=1. State is IDLE.
- Handshake at cycle T, `mxu_rdy`=1 throughout:
  - T+1: CLR, `mxu_clr`.
  - T+2..T+K+1: reads.
  - T+3..T+K+2: `mxu_vld` beats.
  - DRAIN is entered at T+K+2, and `mxu_data_rdy` is checked from T+K+3.
- Minimum latency, no act/pool, `mxu_data_rdy` already 1: `done` at T+K+4.
- `cmd_rdy` returns to 1 the cycle after `done`. No back-to-back overlap.
- `cmd_vld` outside IDLE is ignored and the command is not captured.

## Configuration
- `MXU_SEQ_WATCHDOG_EN` defined: DRAIN counts cycles.
  - On TIMEOUT cycles without `mxu_data_rdy`, set sticky `err`, skip ACT/POOL and go to DONE.
  - `err` is cleared only by `rst` or by the next accepted command.
- Undefined: DRAIN waits indefinitely, no counter is built, and `err` is tied to 0.

## Test plan
- Basic: addr 0x010/0x020, dir 0, len 3, col_len 15, acc 0, `mxu_data_rdy`=1 -> one `mxu_clr`, reads 0x010..0x013 / 0x020..0x023, 4 beats with masks 0xFFFF, `done` at T+8.
- Wrap/dir: iram 0x001 dir 1, wram 0xFFE dir 0, len 3 -> iram 0x001,0x000,0xFFF,0xFFE; wram 0xFFE,0xFFF,0x000,0x001.
- Mask/acc: col_len 4, acc 1 -> `mxu_clr` never asserted, masks 0x001F on both operands.
- Post-ops: act 1 type 2, pool 1 size 1, `mxu_rdy` low 3 cycles in ACT -> act strobe after `mxu_rdy` rises, pool strobe next cycle, then `done`.
- Watchdog: `MXU_SEQ_WATCHDOG_EN`, `mxu_data_rdy` stuck 0 -> `err`=1 and `done` after 255 DRAIN cycles, no act/pool strobes. Without the macro: no `done` after 1000 cycles.
- Reset mid-FEED at beat 2 of 8 -> all outputs 0 in the same cycle, `cmd_rdy`=1, no `done`. The next command runs normally.

Source files
------------

// File: rtl/mxu_conv_seq_if.sv
// Command, RAM read and MXU lane bundle of the conv sequencer.
// master: the sequencer side; slave: the LSU/RAM/MXU environment side.
interface mxu_conv_seq_if #(
  parameter int ADDR_W = 12,
  parameter int LANES  = 16,
  parameter int DATA_W = 128
);
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [ADDR_W-1:0] cmd_iram_addr;
  logic              cmd_iram_dir;
  logic [ADDR_W-1:0] cmd_wram_addr;
  logic              cmd_wram_dir;
  logic [3:0]        cmd_len;
  logic [3:0]        cmd_col_len;
  logic              cmd_acc;
  logic              cmd_act;
  logic [1:0]        cmd_act_type;
  logic              cmd_pool;
  logic [1:0]        cmd_pool_size;
  logic              iram_rd_en;
  logic [ADDR_W-1:0] iram_rd_addr;
  logic [DATA_W-1:0] iram_rd_data;
  logic              wram_rd_en;
  logic [ADDR_W-1:0] wram_rd_addr;
  logic [DATA_W-1:0] wram_rd_data;
  logic              mxu_vld;
  logic              mxu_clr;
  logic [LANES-1:0]  mxu_iram_vld;
  logic [LANES-1:0]  mxu_wram_vld;
  logic [DATA_W-1:0] mxu_iram_pld;
  logic [DATA_W-1:0] mxu_wram_pld;
  logic              mxu_act_vld;
  logic [1:0]        mxu_act_type;
  logic              mxu_pool_vld;
  logic [1:0]        mxu_pool_size;
  logic              mxu_rdy;
  logic              mxu_data_rdy;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  cmd_vld, cmd_iram_addr, cmd_iram_dir, cmd_wram_addr, cmd_wram_dir,
           cmd_len, cmd_col_len, cmd_acc, cmd_act, cmd_act_type, cmd_pool, cmd_pool_size,
           iram_rd_data, wram_rd_data, mxu_rdy, mxu_data_rdy,
    output cmd_rdy, iram_rd_en, iram_rd_addr, wram_rd_en, wram_rd_addr,
           mxu_vld, mxu_clr, mxu_iram_vld, mxu_wram_vld, mxu_iram_pld, mxu_wram_pld,
           mxu_act_vld, mxu_act_type, mxu_pool_vld, mxu_pool_size, busy, done, err
  );

  modport slave (
    output cmd_vld, cmd_iram_addr, cmd_iram_dir, cmd_wram_addr, cmd_wram_dir,
           cmd_len, cmd_col_len, cmd_acc, cmd_act, cmd_act_type, cmd_pool, cmd_pool_size,
           iram_rd_data, wram_rd_data, mxu_rdy, mxu_data_rdy,
    input  cmd_rdy, iram_rd_en, iram_rd_addr, wram_rd_en, wram_rd_addr,
           mxu_vld, mxu_clr, mxu_iram_vld, mxu_wram_vld, mxu_iram_pld, mxu_wram_pld,
           mxu_act_vld, mxu_act_type, mxu_pool_vld, mxu_pool_size, busy, done, err
  );
endinterface

// File: rtl/mxu_conv_seq.sv
// Conv sequencer: clear, stream K operand rows into the MXU, drain, optional act/pool.
// Define MXU_SEQ_WATCHDOG_EN to build the DRAIN timeout counter and sticky err.
module mxu_conv_seq #(
  parameter int ADDR_W  = 12,
  parameter int LANES   = 16,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  mxu_conv_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_ACT   = 3'd4,
    S_POOL  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [ADDR_W-1:0] ia_q, ia_d, wa_q, wa_d;
  logic              idir_q, idir_d, wdir_q, wdir_d;
  logic [3:0]        len_q, len_d, col_q, col_d;
  logic              acc_q, acc_d, act_q, act_d, pool_q, pool_d;
  logic [1:0]        act_type_q, act_type_d, pool_size_q, pool_size_d;
  logic              vld_q, vld_d;

`ifdef MXU_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`else
  logic [31:0] wd_unused_s;
  assign wd_unused_s = 32'(TIMEOUT);
`endif

  function automatic logic [LANES-1:0] lane_mask(input logic [3:0] col);
    logic [LANES-1:0] m;
    m = {LANES{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      m[i] = (i <= int'(col));
    end
    return m;
  endfunction

  // Next-state logic for the command FSM and its captured fields
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ia_d        = ia_q;
    wa_d        = wa_q;
    idir_d      = idir_q;
    wdir_d      = wdir_q;
    len_d       = len_q;
    col_d       = col_q;
    acc_d       = acc_q;
    act_d       = act_q;
    pool_d      = pool_q;
    act_type_d  = act_type_q;
    pool_size_d = pool_size_q;
    vld_d       = (state_q == S_FEED);
`ifdef MXU_SEQ_WATCHDOG_EN
    wd_d        = wd_q;
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_vld) begin
          ia_d        = bus.cmd_iram_addr;
          wa_d        = bus.cmd_wram_addr;
          idir_d      = bus.cmd_iram_dir;
          wdir_d      = bus.cmd_wram_dir;
          len_d       = bus.cmd_len;
          col_d       = bus.cmd_col_len;
          acc_d       = bus.cmd_acc;
          act_d       = bus.cmd_act;
          act_type_d  = bus.cmd_act_type;
          pool_d      = bus.cmd_pool;
          pool_size_d = bus.cmd_pool_size;
          k_d         = 4'd0;
          state_d     = S_CLR;
`ifdef MXU_SEQ_WATCHDOG_EN
          err_d       = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
`ifdef MXU_SEQ_WATCHDOG_EN
        wd_d = {WD_W{1'b0}};
`endif
        if (bus.mxu_rdy) begin
          state_d = S_FEED;
        end else begin
          state_d = S_CLR;
        end
      end
      S_FEED: begin
        if (k_q == len_q) begin
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      // The result is only meaningful once the final beat has left (vld_q low)
      S_DRAIN: begin
        if (vld_q) begin
          state_d = S_DRAIN;
        end else if (bus.mxu_data_rdy) begin
          if (act_q) begin
            state_d = S_ACT;
          end else if (pool_q) begin
            state_d = S_POOL;
          end else begin
            state_d = S_DONE;
          end
        end
`ifdef MXU_SEQ_WATCHDOG_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`else
        else begin
          state_d = S_DRAIN;
        end
`endif
      end
      S_ACT: begin
        if (bus.mxu_rdy) begin
          state_d = pool_q ? S_POOL : S_DONE;
        end else begin
          state_d = S_ACT;
        end
      end
      S_POOL: begin
        if (bus.mxu_rdy) begin
          state_d = S_DONE;
        end else begin
          state_d = S_POOL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and command field registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= 4'd0;
      ia_q        <= {ADDR_W{1'b0}};
      wa_q        <= {ADDR_W{1'b0}};
      idir_q      <= 1'b0;
      wdir_q      <= 1'b0;
      len_q       <= 4'd0;
      col_q       <= 4'd0;
      acc_q       <= 1'b0;
      act_q       <= 1'b0;
      pool_q      <= 1'b0;
      act_type_q  <= 2'd0;
      pool_size_q <= 2'd0;
      vld_q       <= 1'b0;
`ifdef MXU_SEQ_WATCHDOG_EN
      wd_q        <= {WD_W{1'b0}};
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ia_q        <= ia_d;
      wa_q        <= wa_d;
      idir_q      <= idir_d;
      wdir_q      <= wdir_d;
      len_q       <= len_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      act_q       <= act_d;
      pool_q      <= pool_d;
      act_type_q  <= act_type_d;
      pool_size_q <= pool_size_d;
      vld_q       <= vld_d;
`ifdef MXU_SEQ_WATCHDOG_EN
      wd_q        <= wd_d;
      err_q       <= err_d;
`endif
    end
  end

  logic             feed_s;
  logic [LANES-1:0] mask_s;
  assign feed_s = (state_q == S_FEED);
  assign mask_s = lane_mask(col_q);

  assign bus.cmd_rdy       = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.iram_rd_en    = feed_s;
  assign bus.wram_rd_en    = feed_s;
  assign bus.iram_rd_addr  = !feed_s ? {ADDR_W{1'b0}} :
                             (idir_q ? ia_q - ADDR_W'(k_q) : ia_q + ADDR_W'(k_q));
  assign bus.wram_rd_addr  = !feed_s ? {ADDR_W{1'b0}} :
                             (wdir_q ? wa_q - ADDR_W'(k_q) : wa_q + ADDR_W'(k_q));
  // Payloads are zeroed between beats so idle lanes never show stale RAM data
  assign bus.mxu_vld       = vld_q;
  assign bus.mxu_iram_vld  = vld_q ? mask_s : {LANES{1'b0}};
  assign bus.mxu_wram_vld  = vld_q ? mask_s : {LANES{1'b0}};
  assign bus.mxu_iram_pld  = vld_q ? bus.iram_rd_data : {DATA_W{1'b0}};
  assign bus.mxu_wram_pld  = vld_q ? bus.wram_rd_data : {DATA_W{1'b0}};
  assign bus.mxu_clr       = (state_q == S_CLR) & bus.mxu_rdy & ~acc_q;
  assign bus.mxu_act_vld   = (state_q == S_ACT) & bus.mxu_rdy;
  assign bus.mxu_act_type  = act_type_q;
  assign bus.mxu_pool_vld  = (state_q == S_POOL) & bus.mxu_rdy;
  assign bus.mxu_pool_size = pool_size_q;
`ifdef MXU_SEQ_WATCHDOG_EN
  assign bus.err           = err_q;
`else
  assign bus.err           = 1'b0;
`endif

endmodule

// File: tb/tb_mxu_conv_seq.sv
// Directed bench for mxu_conv_seq: a per-command timeline model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_mxu_conv_seq;
  logic clk = 1'b0;
  logic rst;
  mxu_conv_seq_if bus();
  mxu_conv_seq dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Current command plan: absolute cycle numbers of each expected event
  int p_t = -1000, p_clr = -1000, p_rd0 = -1000, p_k = 1;
  int p_act = -1, p_pool = -1, p_done = -999;
  logic [11:0] p_ia = 12'h0, p_wa = 12'h0;
  logic p_idir = 1'b0, p_wdir = 1'b0, p_acc = 1'b0;
  logic [3:0] p_col = 4'h0;
  logic [1:0] p_at = 2'd0, p_ps = 2'd0;
  bit p_stuck = 1'b0;

  int lo_a = -1, lo_b = -2;
  bit stuck = 1'b0;
  bit mon_en = 1'b0;

  logic [11:0] obs_i[$];
  logic [11:0] obs_w[$];
  int clr_cnt, done_cnt, done_obs, act_obs, pool_obs;
  logic [15:0] mask_i_obs, mask_w_obs;
  logic [1:0] at_obs, ps_obs;

  function automatic logic [127:0] ram_word(input logic [11:0] a, input logic [3:0] tag);
    return {8{tag, a}};
  endfunction

  function automatic logic [11:0] addr_at(input logic [11:0] base, input logic dir, input int i);
    logic [11:0] off;
    off = 12'(i);
    return dir ? base - off : base + off;
  endfunction

  function automatic bit rdy_at(input int c);
    return !(c >= lo_a && c <= lo_b);
  endfunction

  function automatic int first_rdy(input int c);
    int x;
    x = c;
    while (!rdy_at(x)) x++;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc %0d got %0h exp %0h", nm, cyc, a, e);
    end
  endtask

  // RAM models: one-cycle read latency, junk when not reading
  always @(posedge clk) begin
    if (bus.iram_rd_en) bus.iram_rd_data <= ram_word(bus.iram_rd_addr, 4'h1);
    else                bus.iram_rd_data <= {4{32'hDEADBEEF}};
    if (bus.wram_rd_en) bus.wram_rd_data <= ram_word(bus.wram_rd_addr, 4'h2);
    else                bus.wram_rd_data <= {4{32'hBAADF00D}};
  end

  // Compare process: every output against the plan, every cycle
  always @(negedge clk) begin : mon
    int c, m;
    bit busy_e, rd_e, vld_e, err_e;
    logic [15:0] m_e;
    if (mon_en) begin
      c = cyc;
      busy_e = (c > p_t) && (c <= p_done);
      chk("busy", bus.busy, busy_e);
      chk("cmd_rdy", bus.cmd_rdy, !busy_e);
      rd_e = (c >= p_rd0) && (c < p_rd0 + p_k);
      chk("iram_rd_en", bus.iram_rd_en, rd_e);
      chk("wram_rd_en", bus.wram_rd_en, rd_e);
      if (rd_e) begin
        chk("iram_rd_addr", bus.iram_rd_addr, addr_at(p_ia, p_idir, c - p_rd0));
        chk("wram_rd_addr", bus.wram_rd_addr, addr_at(p_wa, p_wdir, c - p_rd0));
      end
      vld_e = (c > p_rd0) && (c <= p_rd0 + p_k);
      m = (1 << (int'(p_col) + 1)) - 1;
      m_e = vld_e ? m[15:0] : 16'h0;
      chk("mxu_vld", bus.mxu_vld, vld_e);
      chk("iram_mask", bus.mxu_iram_vld, m_e);
      chk("wram_mask", bus.mxu_wram_vld, m_e);
      if (vld_e) begin
        chk("iram_pld", bus.mxu_iram_pld, ram_word(addr_at(p_ia, p_idir, c - p_rd0 - 1), 4'h1));
        chk("wram_pld", bus.mxu_wram_pld, ram_word(addr_at(p_wa, p_wdir, c - p_rd0 - 1), 4'h2));
      end
      chk("mxu_clr", bus.mxu_clr, (c == p_clr) && !p_acc);
      chk("act_vld", bus.mxu_act_vld, c == p_act);
      if (c == p_act) chk("act_type", bus.mxu_act_type, p_at);
      chk("pool_vld", bus.mxu_pool_vld, c == p_pool);
      if (c == p_pool) chk("pool_size", bus.mxu_pool_size, p_ps);
      chk("done", bus.done, c == p_done);
`ifdef MXU_SEQ_WATCHDOG_EN
      err_e = p_stuck && (c >= p_done);
`else
      err_e = 1'b0;
`endif
      chk("err", bus.err, err_e);
      if (bus.iram_rd_en) obs_i.push_back(bus.iram_rd_addr);
      if (bus.wram_rd_en) obs_w.push_back(bus.wram_rd_addr);
      if (bus.mxu_clr) clr_cnt++;
      if (bus.mxu_vld) begin
        mask_i_obs = bus.mxu_iram_vld;
        mask_w_obs = bus.mxu_wram_vld;
      end
      if (bus.done) begin done_cnt++; done_obs = c; end
      if (bus.mxu_act_vld) begin act_obs = c; at_obs = bus.mxu_act_type; end
      if (bus.mxu_pool_vld) begin pool_obs = c; ps_obs = bus.mxu_pool_size; end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.mxu_rdy = rdy_at(cyc);
    bus.mxu_data_rdy = !stuck;
  endtask

  task automatic start_cmd(input logic [11:0] ia, input logic idr, input logic [11:0] wa,
                           input logic wdr, input logic [3:0] len, input logic [3:0] col,
                           input logic acc, input logic act, input logic [1:0] at,
                           input logic pool, input logic [1:0] ps,
                           input int la, input int lb, input bit stk);
    int t, nxt, chk0;
    t = cyc;
    lo_a = t + la; lo_b = t + lb; stuck = stk;
    bus.cmd_iram_addr = ia; bus.cmd_iram_dir = idr;
    bus.cmd_wram_addr = wa; bus.cmd_wram_dir = wdr;
    bus.cmd_len = len; bus.cmd_col_len = col; bus.cmd_acc = acc;
    bus.cmd_act = act; bus.cmd_act_type = at; bus.cmd_pool = pool; bus.cmd_pool_size = ps;
    bus.cmd_vld = 1'b1;
    obs_i.delete(); obs_w.delete();
    clr_cnt = 0; done_cnt = 0; done_obs = -1; act_obs = -1; pool_obs = -1;
    p_t = t; p_ia = ia; p_idir = idr; p_wa = wa; p_wdir = wdr;
    p_col = col; p_acc = acc; p_at = at; p_ps = ps; p_stuck = stk;
    p_k = int'(len) + 1;
    p_clr = first_rdy(t + 1);
    p_rd0 = p_clr + 1;
    chk0 = p_rd0 + p_k + 1;
    p_act = -1; p_pool = -1;
    if (stk) begin
`ifdef MXU_SEQ_WATCHDOG_EN
      p_done = chk0 + 255;
`else
      p_done = t + 1000000;
`endif
    end else begin
      nxt = chk0 + 1;
      if (act) begin p_act = first_rdy(nxt); nxt = p_act + 1; end
      if (pool) begin p_pool = first_rdy(nxt); nxt = p_pool + 1; end
      p_done = nxt;
    end
    step();
    bus.cmd_vld = 1'b0;
  endtask

  task automatic finish_cmd(input bit inject);
    while (cyc <= p_done && cyc < p_t + 1200) begin
      if (inject && cyc == p_t + 3) begin
        bus.cmd_vld = 1'b1;
        bus.cmd_iram_addr = 12'h7AB;
        bus.cmd_len = 4'hF;
      end else begin
        bus.cmd_vld = 1'b0;
      end
      step();
    end
    bus.cmd_vld = 1'b0;
  endtask

  task automatic idle_outputs(input string nm);
    chk({nm, "_cmd_rdy"}, bus.cmd_rdy, 1'b1);
    chk({nm, "_busy"}, bus.busy, 1'b0);
    chk({nm, "_done"}, bus.done, 1'b0);
    chk({nm, "_rd_en"}, {bus.iram_rd_en, bus.wram_rd_en}, 2'b00);
    chk({nm, "_rd_addr"}, {bus.iram_rd_addr, bus.wram_rd_addr}, 24'h0);
    chk({nm, "_mxu_vld"}, bus.mxu_vld, 1'b0);
    chk({nm, "_mxu_clr"}, bus.mxu_clr, 1'b0);
    chk({nm, "_masks"}, {bus.mxu_iram_vld, bus.mxu_wram_vld}, 32'h0);
    chk({nm, "_ipld"}, bus.mxu_iram_pld, 128'h0);
    chk({nm, "_wpld"}, bus.mxu_wram_pld, 128'h0);
    chk({nm, "_strobes"}, {bus.mxu_act_vld, bus.mxu_pool_vld}, 2'b00);
    chk({nm, "_err"}, bus.err, 1'b0);
  endtask

  initial begin
    logic [11:0] e1[4];
    logic [11:0] e2[4];
    int t;
    rst = 1'b1;
    bus.cmd_vld = 1'b0; bus.cmd_iram_addr = 12'h0; bus.cmd_iram_dir = 1'b0;
    bus.cmd_wram_addr = 12'h0; bus.cmd_wram_dir = 1'b0; bus.cmd_len = 4'h0;
    bus.cmd_col_len = 4'h0; bus.cmd_acc = 1'b0; bus.cmd_act = 1'b0; bus.cmd_act_type = 2'd0;
    bus.cmd_pool = 1'b0; bus.cmd_pool_size = 2'd0;
    bus.mxu_rdy = 1'b1; bus.mxu_data_rdy = 1'b1;
    #1;
    idle_outputs("reset");
    chk("reset_types", {bus.mxu_act_type, bus.mxu_pool_size}, 4'h0);
    step(); step();
    rst = 1'b0;
    mon_en = 1'b1;
    step(); step();

    // Basic, with an ignored cmd_vld pulse mid-command
    t = cyc;
    start_cmd(12'h010, 1'b0, 12'h020, 1'b0, 4'd3, 4'd15, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, -1, -2, 1'b0);
    finish_cmd(1'b1);
    e1 = '{12'h010, 12'h011, 12'h012, 12'h013};
    e2 = '{12'h020, 12'h021, 12'h022, 12'h023};
    chk("basic_nreads", obs_i.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_iaddr", obs_i[i], e1[i]);
      chk("basic_waddr", obs_w[i], e2[i]);
    end
    chk("basic_clr_cnt", clr_cnt, 1);
    chk("basic_done_lat", done_obs - t, 8);
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_mask", mask_i_obs, 16'hFFFF);

    // Wrap in both directions, issued back-to-back after done
    start_cmd(12'h001, 1'b1, 12'hFFE, 1'b0, 4'd3, 4'd15, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, -1, -2, 1'b0);
    finish_cmd(1'b0);
    e1 = '{12'h001, 12'h000, 12'hFFF, 12'hFFE};
    e2 = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    chk("wrap_nreads", obs_w.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_iaddr", obs_i[i], e1[i]);
      chk("wrap_waddr", obs_w[i], e2[i]);
    end

    // Partial lanes, accumulate, mxu_rdy low two cycles during CLR
    step();
    t = cyc;
    start_cmd(12'h3C0, 1'b0, 12'h100, 1'b1, 4'd2, 4'd4, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1, 2, 1'b0);
    finish_cmd(1'b0);
    chk("acc_clr_cnt", clr_cnt, 0);
    chk("acc_imask", mask_i_obs, 16'h001F);
    chk("acc_wmask", mask_w_obs, 16'h001F);
    chk("acc_done_lat", done_obs - t, 9);

    // Activation and pooling with mxu_rdy low three cycles in ACT
    step();
    t = cyc;
    start_cmd(12'h040, 1'b0, 12'h050, 1'b0, 4'd1, 4'd7, 1'b0, 1'b1, 2'd2, 1'b1, 2'd1, 6, 8, 1'b0);
    finish_cmd(1'b0);
    chk("post_act_cyc", act_obs - t, 9);
    chk("post_pool_cyc", pool_obs - t, 10);
    chk("post_done_lat", done_obs - t, 11);
    chk("post_act_type", at_obs, 2'd2);
    chk("post_pool_size", ps_obs, 2'd1);

    // Reset during the second beat of an 8-beat command
    step();
    start_cmd(12'h200, 1'b0, 12'h300, 1'b0, 4'd7, 4'd15, 1'b0, 1'b1, 2'd1, 1'b1, 2'd3, -1, -2, 1'b0);
    while (cyc < p_rd0 + 2) step();
    chk("rst_in_beat", bus.mxu_vld, 1'b1);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    idle_outputs("midrst");
    step(); step();
    rst = 1'b0;
    p_t = -1000; p_clr = -1000; p_rd0 = -1000; p_act = -1; p_pool = -1; p_done = -999;
    p_stuck = 1'b0; p_acc = 1'b0;
    obs_i.delete(); obs_w.delete(); done_cnt = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_reads", obs_i.size(), 0);
    t = cyc;
    start_cmd(12'h0F0, 1'b1, 12'h0A0, 1'b0, 4'd3, 4'd15, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, -1, -2, 1'b0);
    finish_cmd(1'b0);
    chk("after_rst_done_lat", done_obs - t, 8);

    // mxu_data_rdy stuck low
    step();
    t = cyc;
    start_cmd(12'h010, 1'b0, 12'h020, 1'b0, 4'd3, 4'd15, 1'b0, 1'b1, 2'd3, 1'b1, 2'd2, -1, -2, 1'b1);
    finish_cmd(1'b0);
`ifdef MXU_SEQ_WATCHDOG_EN
    chk("wd_done_lat", done_obs - t, 262);
    chk("wd_err", bus.err, 1'b1);
`else
    chk("stuck_no_done", done_cnt, 0);
    chk("stuck_busy", bus.busy, 1'b1);
`endif
    chk("stuck_no_act", act_obs, -1);
    chk("stuck_no_pool", pool_obs, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
